sms_sports_pad: RTL and testbench
=================================

// Module: sms_sports_pad
// PURPOSE
//  Peripheral-side model of a Master System controller plugged into a joypad port; the console
//  I/O block reads it. Two modes: Sports Pad (trackball) and paddle.
//  Sports Pad: the console's TH output steps the pad through four data nibbles.
//  Paddle: a free-running TR-phase toggle multiplexes an 8-bit position onto the four direction pins.
//  Its pin-level outputs feed the console's J1_*/J2_* inputs; its th input is the console's J*_th_out.
// PARAMETERS
//  TW            16    width of the timeout and paddle-phase counters
//  TIMEOUT       2048  clocks with no TH edge before Sports Pad returns to IDLE
//  PADDLE_HALF   4096  clocks per paddle phase (half period of TR toggle)
// PORTS
//  clk         in   1  system clock
//  RESET       in   1  asynchronous reset, active-high
//  mode        in   1  0 = Sports Pad, 1 = paddle
//  th          in   1  TH level driven by the console (1 = high)
//  dx_stb      in   1  one-cycle strobe: add dx to X accumulator
//  dx          in   8  signed X motion, right positive
//  dy_stb      in   1  one-cycle strobe: add dy to Y accumulator
//  dy          in   8  signed Y motion, down positive
//  paddle_pos  in   8  absolute paddle position (paddle mode)
//  btn1        in   1  button 1 pressed (active-high)
//  btn2        in   1  button 2 pressed (active-high)
//  up,down,left,right out 1  pin levels; carry nibble bits 0,1,2,3 respectively
//  tl          out  1  pin level; ~btn1, registered
//  tr          out  1  Sports Pad: ~btn2; paddle: phase flag
// BEHAVIOUR
//  Reset: all six outputs = 1; state IDLE; index = 0.
//  Reset also clears: accX/accY = 0, snapX/snapY = 0, th_q = 1, timeout counter = 0, phase = 0.
//  Outputs are registered. A pin change takes effect on the clock after the cause.
//  TH edge: detected when th != th_q (th_q = th registered each clock). Either polarity counts.
//  Nibble pins therefore update 2 clocks after th changes.
//  Accumulators: accX += dx on dx_stb (likewise Y). Signed 8-bit, saturating: clamp to +127 / -128, never wrap.
//  Sports Pad FSM (mode = 0):
//   IDLE  : first TH edge -> snapX/Y <= accX/Y; accX/Y <= 0 (plus any same-cycle strobe delta,
//           which goes to the residual, not the snapshot); index <= 0; -> ACTIVE; timer <= 0.
//   ACTIVE: each TH edge -> index <= index + 1 mod 4 (wraps 3->0, no re-latch); timer <= 0.
//           No edge: timer++. When timer reaches TIMEOUT-1 -> IDLE, index <= 0. An edge on that same cycle wins.
//   Nibble mapping by index: 0 = snapX[7:4], 1 = snapX[3:0], 2 = snapY[7:4], 3 = snapY[3:0].
//   In both states the pins show nibble[index] of the current snapshot.
//   tl = ~btn1; tr = ~btn2.
//  Paddle mode (mode = 1):
//   - th and the FSM are ignored.
//   - phase toggles every PADDLE_HALF clocks.
//   - phase 0: nibble = paddle_pos[3:0], tr = 0. phase 1: nibble = paddle_pos[7:4], tr = 1.
//   - tl = ~btn1. paddle_pos is sampled every cycle.
//   - Accumulators keep integrating.
//  Mode change (any cycle mode differs from its registered copy):
//   - Clears: state IDLE, index 0, timeout and phase counters, phase 0.
//   - Preserves: accumulators and snapshot.
//  Reset asserted mid-sequence: immediate return to reset values; no partial nibble is held.
// TESTING
//  1 Reset, mode=0, no motion -> all pins 1 during reset.
//    One clock after release, pins = nibble 0x0 (up..right = 0), tl = tr = 1.
//  2 mode=0, dx_stb x5 with dx=+3, dy_stb x1 with dy=-2, then 5 TH toggles 10 clocks apart.
//    Nibbles must read 0x0, 0xF, 0xF, 0xE, then 0x0 (wrap, no re-latch). accX = accY = 0 after the latch.
//  3 200 dx_stb with dx=+1, then 150 with dx=-1, then latch -> snapX = 0x7F then... (see note):
//    per-strobe saturation gives 127 - 150 = -23 = 0xE9; 128 dx=-1 from 0 -> accX = 0x80, no wrap.
//  4 After a latch, advance index to 2, then hold th for TIMEOUT clocks.
//    Required: IDLE, index 0, pins = snapX[7:4]. The next edge re-latches.
//  5 dx_stb (dx=+4) on the same cycle as the IDLE-latching edge with accX = 6.
//    Required: snapX = 6, accX = 4 afterwards.
//  6 mode=1, paddle_pos = 0xA5, btn1 = 1.
//    Required: tl = 0; pins 0x5 with tr = 0 for PADDLE_HALF clocks, then 0xA with tr = 1.
//    th toggling has no effect.

Source files
------------

// File: rtl/sms_sports_pad.sv
// Master System Sports Pad / paddle controller, peripheral side.
// TH-stepped trackball nibbles (mode 0) or a free-running paddle phase multiplex (mode 1).
module sms_sports_pad #(
  parameter int TW          = 16,
  parameter int TIMEOUT     = 2048,
  parameter int PADDLE_HALF = 4096
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       mode,
  input  logic       th,
  input  logic       dx_stb,
  input  logic [7:0] dx,
  input  logic       dy_stb,
  input  logic [7:0] dy,
  input  logic [7:0] paddle_pos,
  input  logic       btn1,
  input  logic       btn2,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       tl,
  output logic       tr
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] PHASE_LAST = TW'(PADDLE_HALF - 1);

  state_t        state_q;
  logic [1:0]    idx_q;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] pcnt_q,  pcnt_d;
  logic          phase_q, phase_d;
  logic          mode_q;
  logic          th_q;
  logic [7:0]    accx_q,  accx_d;
  logic [7:0]    accy_q,  accy_d;
  logic [7:0]    snapx_q, snapy_q;
  logic [3:0]    nib_q;
  logic          tl_q, tr_q;

  logic          th_edge;
  logic          mode_chg;
  logic          latch;
  logic [3:0]    sport_nib;
  logic [3:0]    pad_nib;

  // Signed 8-bit add that clamps to +127 / -128 instead of wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] s;
    s = $signed({a[7], a}) + $signed({b[7], b});
    if (s > 9'sd127)       return 8'h7F;
    else if (s < -9'sd128) return 8'h80;
    else                   return s[7:0];
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    th_edge  = (th != th_q);
    mode_chg = (mode != mode_q);
    latch    = !mode && !mode_chg && (state_q == IDLE) && th_edge;

    accx_d = dx_stb ? sat_add(accx_q, dx) : accx_q;
    accy_d = dy_stb ? sat_add(accy_q, dy) : accy_q;
    // A strobe landing on the latching edge belongs to the residual, not the snapshot.
    if (latch) begin
      accx_d = dx_stb ? dx : 8'h00;
      accy_d = dy_stb ? dy : 8'h00;
    end

    pcnt_d  = pcnt_q;
    phase_d = phase_q;
    if (mode_chg) begin
      pcnt_d  = '0;
      phase_d = 1'b0;
    end else if (mode) begin
      if (pcnt_q == PHASE_LAST) begin
        pcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end

    sport_nib = snapx_q[7:4];
    case (idx_q)
      2'd0: sport_nib = snapx_q[7:4];
      2'd1: sport_nib = snapx_q[3:0];
      2'd2: sport_nib = snapy_q[7:4];
      2'd3: sport_nib = snapy_q[3:0];
      default: sport_nib = snapx_q[7:4];
    endcase

    // Paddle pins follow the phase being entered this clock so tr and nibble change together.
    pad_nib = phase_d ? paddle_pos[7:4] : paddle_pos[3:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      timer_q <= '0;
      pcnt_q  <= '0;
      phase_q <= 1'b0;
      mode_q  <= 1'b0;
      th_q    <= 1'b1;
      accx_q  <= 8'h00;
      accy_q  <= 8'h00;
      snapx_q <= 8'h00;
      snapy_q <= 8'h00;
      nib_q   <= 4'hF;
      tl_q    <= 1'b1;
      tr_q    <= 1'b1;
    end else begin
      mode_q  <= mode;
      th_q    <= th;
      accx_q  <= accx_d;
      accy_q  <= accy_d;
      pcnt_q  <= pcnt_d;
      phase_q <= phase_d;
      tl_q    <= ~btn1;

      if (mode) begin
        nib_q <= pad_nib;
        tr_q  <= phase_d;
      end else begin
        nib_q <= sport_nib;
        tr_q  <= ~btn2;
      end

      if (mode_chg) begin
        state_q <= IDLE;
        idx_q   <= 2'd0;
        timer_q <= '0;
      end else if (!mode) begin
        case (state_q)
          IDLE: begin
            if (th_edge) begin
              snapx_q <= accx_q;
              snapy_q <= accy_q;
              idx_q   <= 2'd0;
              timer_q <= '0;
              state_q <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (th_edge) begin
              idx_q   <= idx_q + 2'd1;
              timer_q <= '0;
            end else if (timer_q == TIMER_LAST) begin
              state_q <= IDLE;
              idx_q   <= 2'd0;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            timer_q <= '0;
          end
        endcase
      end
    end
  end

  assign up    = nib_q[0];
  assign down  = nib_q[1];
  assign left  = nib_q[2];
  assign right = nib_q[3];
  assign tl    = tl_q;
  assign tr    = tr_q;

endmodule

// File: tb/tb_sms_sports_pad.sv
// Scoreboard bench for sms_sports_pad: expectations are queued when stimulus is applied
// and compared when the registered pins are sampled.
module tb_sms_sports_pad;

  localparam int TIMEOUT = 2048;
  localparam int PH      = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode, th, dx_stb, dy_stb, btn1, btn2;
  logic [7:0] dx, dy, paddle_pos;
  logic       up, down, left, right, tl, tr;
  logic [5:0] pins_obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  sms_sports_pad #(.TW(16), .TIMEOUT(TIMEOUT), .PADDLE_HALF(PH)) dut (
    .clk(clk), .RESET(rst), .mode(mode), .th(th),
    .dx_stb(dx_stb), .dx(dx), .dy_stb(dy_stb), .dy(dy),
    .paddle_pos(paddle_pos), .btn1(btn1), .btn2(btn2),
    .up(up), .down(down), .left(left), .right(right), .tl(tl), .tr(tr)
  );

  always #5 clk = ~clk;

  assign pins_obs = {tr, tl, right, left, down, up};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stb_x(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      dx_stb = 1'b1; dx = v; tick(); dx_stb = 1'b0;
    end
  endtask

  task automatic stb_y(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      dy_stb = 1'b1; dy = v; tick(); dy_stb = 1'b0;
    end
  endtask

  // Buttons released: tl = tr = 1 in Sports Pad mode.
  task automatic toggle(input string tag, input logic [3:0] nib);
    push(tag, {26'd0, 2'b11, nib});
    th = ~th;
    tick();
    tick();
    pop_check({26'd0, pins_obs});
  endtask

  task automatic go_idle();
    repeat (TIMEOUT + 4) tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo_len, hi_len, bad_lo, bad_hi, n;

    rst = 1'b1; mode = 1'b0; th = 1'b1; dx_stb = 1'b0; dy_stb = 1'b0;
    dx = 8'h00; dy = 8'h00; paddle_pos = 8'h00; btn1 = 1'b0; btn2 = 1'b0;

    // 1: reset values, then nibble 0 of an empty snapshot
    #1;
    check("rst_pins", {26'd0, pins_obs}, 32'h3F);
    repeat (3) tick();
    check("rst_hold", {26'd0, pins_obs}, 32'h3F);
    rst = 1'b0;
    tick();
    check("rst_release", {26'd0, pins_obs}, 32'h30);

    // 2: X = +15, Y = -2, five edges with wrap
    stb_x(8'd3, 5);
    stb_y(8'hFE, 1);
    toggle("t2_n0", 4'h0); repeat (8) tick();
    toggle("t2_n1", 4'hF); repeat (8) tick();
    toggle("t2_n2", 4'hF); repeat (8) tick();
    toggle("t2_n3", 4'hE); repeat (8) tick();
    toggle("t2_wrap", 4'h0); repeat (8) tick();

    // 4: advance to index 2, then timeout boundary
    toggle("t4_n1", 4'hF);
    toggle("t4_n2", 4'hF);
    push("t4_pre_timeout", 32'h3F);
    push("t4_timeout", 32'h30);
    repeat (TIMEOUT - 1) tick();
    pop_check({26'd0, pins_obs});
    tick();
    pop_check({26'd0, pins_obs});
    // re-latch: accumulators were cleared by the first latch
    toggle("t4_relatch0", 4'h0);
    toggle("t4_relatch1", 4'h0);
    toggle("t4_relatch2", 4'h0);
    toggle("t4_relatch3", 4'h0);

    // 3: saturation
    go_idle();
    stb_x(8'h01, 200);
    stb_x(8'hFF, 150);
    toggle("t3_x_hi", 4'hE);
    toggle("t3_x_lo", 4'h9);
    toggle("t3_y_hi", 4'h0);
    toggle("t3_y_lo", 4'h0);
    go_idle();
    stb_x(8'hFF, 128);
    stb_y(8'h01, 130);
    toggle("t3_neg_hi", 4'h8);
    toggle("t3_neg_lo", 4'h0);
    toggle("t3_pos_hi", 4'h7);
    toggle("t3_pos_lo", 4'hF);

    // 5: strobe on the latching edge goes to the residual
    go_idle();
    stb_x(8'd6, 1);
    push("t5_snap_hi", 32'h30);
    th = ~th; dx_stb = 1'b1; dx = 8'd4;
    tick();
    dx_stb = 1'b0;
    tick();
    pop_check({26'd0, pins_obs});
    toggle("t5_snap_lo", 4'h6);
    toggle("t5_y_hi", 4'h0);
    toggle("t5_y_lo", 4'h0);
    stb_x(8'h30, 1);
    go_idle();
    toggle("t5_resid_hi", 4'h3);
    toggle("t5_resid_lo", 4'h4);

    // 6: paddle mode, th toggling ignored, accumulators keep integrating
    btn1 = 1'b1; mode = 1'b1; paddle_pos = 8'hA5;
    push("pad_first", 32'h05);
    push("pad_lo_len", PH);
    push("pad_lo_bad", 0);
    push("pad_hi_len", PH);
    push("pad_hi_bad", 0);
    tick();
    pop_check({26'd0, pins_obs});
    lo_len = 1; bad_lo = 0; n = 0;
    while (n < 3 * PH) begin
      n++;
      if (n == 3) begin dx_stb = 1'b1; dx = 8'h52; end
      if (n == 4) dx_stb = 1'b0;
      if (n % 5 == 0) th = ~th;
      tick();
      if (pins_obs[5]) break;
      lo_len++;
      if (pins_obs != 6'h05) bad_lo++;
    end
    hi_len = 1; bad_hi = (pins_obs != 6'h2A) ? 1 : 0;
    while (n < 6 * PH) begin
      n++;
      if (n % 7 == 0) th = ~th;
      tick();
      if (!pins_obs[5]) break;
      hi_len++;
      if (pins_obs != 6'h2A) bad_hi++;
    end
    pop_check(lo_len);
    pop_check(bad_lo);
    pop_check(hi_len);
    pop_check(bad_hi);

    // back to Sports Pad: snapshot preserved, index 0, integrated motion latched next
    btn1 = 1'b0; mode = 1'b0;
    push("mode_back", 32'h33);
    tick();
    pop_check({26'd0, pins_obs});
    toggle("pad_acc_hi", 4'h5);
    toggle("pad_acc_lo", 4'h2);

    // reset mid-sequence clears everything immediately
    stb_x(8'h11, 1);
    rst = 1'b1; th = 1'b1;
    #1;
    check("midrst_async", {26'd0, pins_obs}, 32'h3F);
    tick();
    check("midrst_hold", {26'd0, pins_obs}, 32'h3F);
    rst = 1'b0;
    tick();
    check("midrst_release", {26'd0, pins_obs}, 32'h30);
    toggle("midrst_hi", 4'h0);
    toggle("midrst_lo", 4'h0);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
